// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: state encoding, PC step and reset default.
package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/yMux.sv
// Generic SIZE-bit 2:1 mux: z = c ? b : a.
module yMux #(
    parameter int unsigned SIZE = 32
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c
);

    assign z = c ? b : a;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: IDLE/RUN/HALTED handshake FSM with jump > branch > sequential selection.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned SIZE     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ready_in,
    input  logic            jump,
    input  logic [SIZE-1:0] jump_tgt,
    input  logic            branch_take,
    input  logic [SIZE-1:0] branch_off,
    input  logic            halt,
    output logic [SIZE-1:0] pc_out,
    output logic [SIZE-1:0] pc4_out,
    output logic            valid_out,
    output logic            halted,
    output logic [15:0]     fetch_cnt
);

    localparam logic [SIZE-1:0] ALIGN_MASK = {{(SIZE-2){1'b1}}, 2'b00};

    fetch_state_e    state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            fire;
    logic [SIZE-1:0] seq_pc, br_pc, seq_or_br, sel_pc, next_pc;

    assign seq_pc = pc_q + SIZE'(PC_STEP);
    assign br_pc  = pc_q + branch_off;

    yMux #(.SIZE(SIZE)) u_mux_branch (
        .z (seq_or_br),
        .a (seq_pc),
        .b (br_pc),
        .c (branch_take)
    );

    yMux #(.SIZE(SIZE)) u_mux_jump (
        .z (sel_pc),
        .a (seq_or_br),
        .b (jump_tgt),
        .c (jump)
    );

    assign next_pc = sel_pc & ALIGN_MASK;
    assign fire    = valid_out & ready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC[SIZE-1:0];
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (fire) begin
                    // Halt wins over any redirect and freezes the PC on the accepted address.
                    if (halt) state_d = StHalted;
                    else      pc_d    = next_pc;
                end
            end
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
        if (fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_comb begin
        valid_out = (state_q == StRun);
        halted    = (state_q == StHalted);
        pc_out    = pc_q;
        pc4_out   = pc_q + SIZE'(PC_STEP);
        fetch_cnt = cnt_q;
    end

endmodule
